// File: rtl/ifu_pkg.sv
// Shared fetch-stage constants and PC target helpers, reusable by later pipeline stages.
// Helpers work on 64-bit word addresses; callers keep the low PC-width bits (mod 2^PC_WIDTH).
package ifu_pkg;

    localparam int INSTR_W = 32;
    localparam int JADDR_W = 26;
    localparam int IMM_W   = 16;

    function automatic logic [63:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(64-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    // Branch offsets are relative to the sequential pc (no delay slot).
    function automatic logic [63:0] branch_target(input logic [63:0]      pc,
                                                  input logic [IMM_W-1:0] imm);
        return pc + 64'd1 + sext_imm(imm);
    endfunction

    // Upper bits come from the sequential pc; for narrow PCs truncation leaves addr only.
    function automatic logic [63:0] jump_target(input logic [63:0]        pc,
                                                input logic [JADDR_W-1:0] addr);
        logic [63:0] seq;
        seq = pc + 64'd1;
        return {seq[63:JADDR_W], addr};
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; push/pop take effect on the next edge, no read bypass.
// Flush wins over push and pop; push when full and pop when empty are ignored.
module ifu_fifo #(
    parameter int WIDTH = 62,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign pop_dat = mem[rd_ptr];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/ifu_pipe.sv
// Decoupled fetch: credit-limited imem requests, buffered words to decode, redirect squash.
// Fetch-to-decode = memory latency + 1; requests stop once outstanding+buffered reaches DEPTH.
module ifu_pipe
    import ifu_pkg::*;
#(
    parameter int                  PC_WIDTH = 30,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [PC_WIDTH+1:0]  imem_addr,
    input  logic                 imem_ready,
    input  logic                 imem_rvalid,
    input  logic [INSTR_W-1:0]   imem_rdata,
    output logic                 instr_valid,
    output logic [INSTR_W-1:0]   instruction,
    output logic [PC_WIDTH-1:0]  instr_pc,
    input  logic                 instr_ready,
    input  logic                 is_jump,
    input  logic                 is_branch,
    input  logic [IMM_W-1:0]     imm16,
    input  logic [JADDR_W-1:0]   addr26
);

    localparam int                  CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]       DEPTH_C = CW'(DEPTH);
    localparam logic [PC_WIDTH-1:0] PC_ONE  = 1;

    logic [PC_WIDTH-1:0]         fetch_pc, fetch_pc_nx;
    logic [PC_WIDTH-1:0]         tail_pc, tail_pc_nx;
    logic [CW-1:0]               credits, credits_nx;
    logic [CW-1:0]               drop_cnt, drop_nx;
    logic [CW-1:0]               fifo_cnt;
    logic [CW-1:0]               inflight;
    logic [PC_WIDTH+INSTR_W-1:0] head_dat;
    logic [PC_WIDTH-1:0]         head_pc;
    logic [PC_WIDTH-1:0]         target;
    logic                        fifo_empty, fifo_full;
    logic                        accept, consume, redirect, dropping, push;

    assign head_pc     = head_dat[PC_WIDTH+INSTR_W-1:INSTR_W];
    assign instr_valid = ~fifo_empty & ~reset;
    assign instruction = instr_valid ? head_dat[INSTR_W-1:0] : '0;
    assign instr_pc    = instr_valid ? head_pc : '0;
    assign imem_req    = (credits < DEPTH_C) & ~reset;
    assign imem_addr   = reset ? '0 : {fetch_pc, 2'b00};

    assign accept   = imem_req & imem_ready;
    assign consume  = instr_valid & instr_ready;
    assign redirect = consume & (is_jump | is_branch);
    // A word arriving with a redirect belongs to the old path.
    assign dropping = imem_rvalid & (redirect | (drop_cnt != '0));
    assign push     = imem_rvalid & ~dropping & ~fifo_full;
    assign inflight = credits - fifo_cnt;

    always_comb begin
        target = is_jump ? PC_WIDTH'(jump_target(64'(head_pc), addr26))
                         : PC_WIDTH'(branch_target(64'(head_pc), imm16));
    end

    always_comb begin
        fetch_pc_nx = fetch_pc;
        tail_pc_nx  = tail_pc;
        credits_nx  = credits;
        drop_nx     = drop_cnt;
        if (redirect) begin
            // Everything still in flight after this edge is wrong-path.
            fetch_pc_nx = target;
            tail_pc_nx  = target;
            drop_nx     = inflight + CW'(accept) - CW'(imem_rvalid);
            credits_nx  = drop_nx;
        end else begin
            if (accept)   fetch_pc_nx = fetch_pc + PC_ONE;
            if (push)     tail_pc_nx  = tail_pc + PC_ONE;
            if (dropping) drop_nx     = drop_cnt - CW'(1);
            credits_nx = credits + CW'(accept) - CW'(consume) - CW'(dropping);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            tail_pc  <= RESET_PC;
            credits  <= '0;
            drop_cnt <= '0;
        end else begin
            fetch_pc <= fetch_pc_nx;
            tail_pc  <= tail_pc_nx;
            credits  <= credits_nx;
            drop_cnt <= drop_nx;
        end
    end

    ifu_fifo #(
        .WIDTH (PC_WIDTH + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .push     (push),
        .push_dat ({tail_pc, imem_rdata}),
        .pop      (consume),
        .flush    (redirect),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

endmodule

// File: tb/tb_ifu_pipe.sv
// Random memory latency / backpressure / redirect bench with an architectural pc-stream model.
module tb_ifu_pipe;

    localparam int              PCW    = 30;
    localparam int              DEPTH  = 4;
    localparam logic [PCW-1:0]  RST_PC = 30'h100;
    localparam longint          MASK   = (64'sd1 <<< PCW) - 1;
    localparam int              ND     = 7;

    logic           clk = 0;
    logic           reset = 1;
    logic           imem_req;
    logic [PCW+1:0] imem_addr;
    logic           imem_ready = 0;
    logic           imem_rvalid = 0;
    logic [31:0]    imem_rdata = 0;
    logic           instr_valid;
    logic [31:0]    instruction;
    logic [PCW-1:0] instr_pc;
    logic           instr_ready = 0;
    logic           is_jump = 0;
    logic           is_branch = 0;
    logic [15:0]    imm16 = 0;
    logic [25:0]    addr26 = 0;

    ifu_pipe #(.PC_WIDTH(PCW), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .is_jump(is_jump), .is_branch(is_branch),
        .imm16(imm16), .addr26(addr26)
    );

    always #5 clk = ~clk;

    typedef struct { longint pc; int due; } req_t;
    req_t   mq[$];
    int     n_cmp = 0, n_bad = 0, cyc = 0;
    longint m_fetch, m_exp;
    int     p_ready, p_ir, p_redir, lat_max;
    bit     directed = 0;
    int     di = 0;
    longint pend_lit;
    bit     pend_vld = 0;
    bit     s_req, s_valid, s_acc;
    longint s_addr, s_pc;

    longint      d_pc  [ND] = '{64'h103, 64'h5, 64'h3, 64'h400_0000, 64'h400_0010, 64'h400_0100, 64'h400_0111};
    bit          d_j   [ND] = '{1, 0, 1, 1, 1, 0, 1};
    bit          d_b   [ND] = '{0, 1, 0, 0, 0, 1, 1};
    logic [15:0] d_imm [ND] = '{16'h0, 16'hFFFD, 16'h0, 16'h0, 16'h0, 16'h0010, 16'h7777};
    logic [25:0] d_a   [ND] = '{26'h5, 26'h0, 26'h3FF_FFFF, 26'h10, 26'h100, 26'h0, 26'h20};
    longint      d_exp [ND] = '{64'h5, 64'h3, 64'h3FF_FFFF, 64'h400_0010, 64'h400_0100, 64'h400_0111, 64'h400_0020};

    function automatic logic [31:0] mdata(input longint pc);
        logic [31:0] p;
        p = pc[31:0];
        return (p * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic longint bt(input longint pc, input logic [15:0] imm);
        return (pc + 1 + longint'($signed(imm))) & MASK;
    endfunction

    function automatic longint jt(input longint pc, input logic [25:0] a);
        return (((pc + 1) & MASK) & ~longint'(64'h3FF_FFFF)) | longint'(a);
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit     consume, accept, redir;
        longint tgt;
        @(negedge clk);
        cyc++;
        s_req = imem_req; s_valid = instr_valid; s_addr = longint'(imem_addr); s_pc = longint'(instr_pc);
        if (imem_req) check("imem_addr", longint'(imem_addr), m_fetch << 2);
        if (instr_valid) begin
            check("instr_pc", longint'(instr_pc), m_exp);
            check("instruction", longint'(instruction), longint'(mdata(m_exp)));
        end
        imem_ready  = ($urandom_range(99) < p_ready);
        instr_ready = ($urandom_range(99) < p_ir);
        imm16 = 16'($urandom); addr26 = 26'($urandom);
        is_jump = 1'($urandom_range(1)); is_branch = 1'($urandom_range(1));
        consume = instr_valid && instr_ready;
        redir = 0;
        if (consume) begin
            is_jump = 0; is_branch = 0;
            if (pend_vld) begin
                check("dir_target", longint'(instr_pc), pend_lit);
                pend_vld = 0;
            end
            if (directed) begin
                if (di < ND && m_exp == d_pc[di]) begin
                    is_jump = d_j[di]; is_branch = d_b[di]; imm16 = d_imm[di]; addr26 = d_a[di];
                    pend_lit = d_exp[di]; pend_vld = 1; di++; redir = 1;
                end
            end else if ($urandom_range(99) < p_redir) begin
                case ($urandom_range(2))
                    0: is_jump = 1;
                    1: is_branch = 1;
                    default: begin is_jump = 1; is_branch = 1; end
                endcase
                redir = 1;
            end
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1; imem_rdata = mdata(mq[0].pc); void'(mq.pop_front());
        end else begin
            imem_rvalid = 0; imem_rdata = $urandom;
        end
        accept = imem_req && imem_ready;
        s_acc = accept;
        if (accept) begin
            mq.push_back('{m_fetch, cyc + int'($urandom_range(lat_max, 1))});
            check("outstanding_le_depth", longint'(mq.size() <= DEPTH), 1);
        end
        if (redir) begin
            tgt = is_jump ? jt(m_exp, addr26) : bt(m_exp, imm16);
            m_fetch = tgt; m_exp = tgt;
        end else begin
            if (accept)  m_fetch = (m_fetch + 1) & MASK;
            if (consume) m_exp   = (m_exp + 1) & MASK;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fetch = longint'(RST_PC); m_exp = longint'(RST_PC); pend_vld = 0;
    endtask

    initial begin
        int acc;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_req", longint'(imem_req), 0);
        check("reset_valid", longint'(instr_valid), 0);
        check("reset_addr", longint'(imem_addr), 0);
        reset = 0;

        // Decode stalled from empty: exactly DEPTH requests, then the request line drops.
        p_ready = 100; p_ir = 0; p_redir = 0; lat_max = 1; acc = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            acc += int'(s_acc);
        end
        check("bp_accepts", longint'(acc), 4);
        check("bp_req_low", longint'(s_req), 0);
        check("bp_head_valid", longint'(s_valid), 1);
        check("bp_head_pc", s_pc, 64'h100);

        directed = 1; p_ready = 80; p_ir = 90; lat_max = 3;
        for (int k = 0; k < 600 && (di < ND || pend_vld); k++) step();
        check("directed_done", longint'(di), ND);
        check("directed_last_seen", longint'(pend_vld), 0);
        directed = 0; pend_vld = 0;

        p_ready = 60; p_ir = 70; p_redir = 15; lat_max = 3;
        for (int k = 0; k < 3000; k++) step();
        p_ready = 50; p_ir = 100; p_redir = 30;
        for (int k = 0; k < 1000; k++) step();

        // Asynchronous reset between edges must clear outputs immediately.
        #2 reset = 1;
        #1;
        check("midrst_req", longint'(imem_req), 0);
        check("midrst_valid", longint'(instr_valid), 0);
        check("midrst_addr", longint'(imem_addr), 0);
        check("midrst_pc", longint'(instr_pc), 0);
        imem_ready = 0; imem_rvalid = 0; instr_ready = 0; is_jump = 0; is_branch = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 0;

        p_ready = 100; p_ir = 100; p_redir = 0; lat_max = 1;
        step();
        check("sl_addr0", s_addr, 64'h400);
        check("sl_valid0", longint'(s_valid), 0);
        step();
        check("sl_addr1", s_addr, 64'h404);
        step();
        check("sl_addr2", s_addr, 64'h408);
        check("sl_valid2", longint'(s_valid), 1);
        check("sl_pc2", s_pc, 64'h100);
        step();
        check("sl_pc3", s_pc, 64'h101);
        check("sl_req3", longint'(s_req), 1);

        p_ready = 70; p_ir = 80; p_redir = 10; lat_max = 3;
        for (int k = 0; k < 800; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
